// File: rtl/max_pool_layer.sv
// Sequential 1-D max-pooling stage: emits the signed maximum of each non-overlapping
// window of POOL_SIZE accepted words through a registered valid-ready output.
module max_pool_layer #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned POOL_SIZE = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic                        ready_o,
    input  logic                        valid_i,
    input  logic signed [WORD_SIZE-1:0] data_r_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic signed [WORD_SIZE-1:0] data_r_o
);

    localparam int unsigned CntW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(POOL_SIZE - 1);

    logic [CntW-1:0]             count_q, count_d;
    logic signed [WORD_SIZE-1:0] max_q, max_d;
    logic signed [WORD_SIZE-1:0] data_d;
    logic                        valid_d;

    logic                        last_word;
    logic                        accept;
    logic                        drain;
    logic signed [WORD_SIZE-1:0] running_max;

    assign last_word = (count_q == LastCnt);

    // Only the final word of a window can be blocked by a stalled result.
    assign ready_o = !(valid_o && !ready_i && last_word);
    assign accept  = valid_i && ready_o;
    assign drain   = valid_o && ready_i;

    // Strict compare keeps the current maximum on ties.
    assign running_max = (data_r_i > max_q) ? data_r_i : max_q;

    always_comb begin
        count_d = count_q;
        max_d   = max_q;
        data_d  = data_r_o;
        valid_d = valid_o;

        if (drain) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (last_word) begin
                count_d = '0;
                data_d  = running_max;
                valid_d = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
                max_d   = (count_q == '0) ? data_r_i : running_max;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= '0;
            max_q    <= '0;
            valid_o  <= 1'b0;
            data_r_o <= '0;
        end else begin
            count_q  <= count_d;
            max_q    <= max_d;
            valid_o  <= valid_d;
            data_r_o <= data_d;
        end
    end

endmodule

// File: doc/max_pool_layer.md
# max_pool_layer

Sequential 1-D max-pooling stage that sits directly downstream of `abs_layer` in the CNN datapath. It consumes one signed word per handshake and forms non-overlapping windows of `POOL_SIZE` consecutive words. For each window it emits one word: the signed maximum of that window. It is a helpful producer and consumer, using valid-ready on both sides, with a registered output.

## Interface
Parameters:
- `WORD_SIZE`, default 16: bit width of input and output words (signed, two's complement).
- `POOL_SIZE`, default 4: number of inputs per window. Legal range is 2 to 256; the window stride equals `POOL_SIZE`.

Ports:
- `clk_i`, input, 1: clock; all state changes on its rising edge.
- `reset_i`, input, 1: synchronous, active-high reset.
- `ready_o`, output, 1: this layer can accept `data_r_i` this cycle.
- `valid_i`, input, 1: previous layer presents valid `data_r_i`.
- `data_r_i`, input, `WORD_SIZE`, signed: input word from the previous layer's register.
- `valid_o`, output, 1: `data_r_o` holds a completed window maximum; registered.
- `ready_i`, input, 1: next layer accepts `data_r_o` this cycle.
- `data_r_o`, output, `WORD_SIZE`, signed: window maximum; driven directly from a register.

## Operation
Handshake events:
- Accept: `valid_i && ready_o` at a rising edge.
- Drain: `valid_o && ready_i` at a rising edge.

Internal state:
- `count_r`: window position, 0 to `POOL_SIZE-1`, width `$clog2(POOL_SIZE)`.
- `max_r`: running maximum, `WORD_SIZE` bits, signed.
- `data_r_o` register and `valid_o` register.

Accept, non-final (`count_r < POOL_SIZE-1`):
- If `count_r == 0`, then `max_r <= data_r_i`.
- Otherwise `max_r <= (data_r_i > max_r) ? data_r_i : max_r`, using a signed compare.
- `count_r` increments.
- The output register is untouched.

Accept, final (`count_r == POOL_SIZE-1`):
- `data_r_o` <= signed max(`max_r`, `data_r_i`).
- `valid_o` <= 1.
- `count_r` <= 0.
- `max_r` is don't-care.

Tie handling: on equal values the current maximum is kept. Results are bit-identical either way.

Drain without a same-cycle final accept: `valid_o` <= 0 and `data_r_o` holds its value.

Drain and final accept in the same cycle: the new result loads and `valid_o` stays 1. This gives full throughput with no bubble.

`ready_o` is combinational: `ready_o = !(valid_o && !ready_i && count_r == POOL_SIZE-1)`.
- Non-final words are always accepted, even while a result is stalled.
- `ready_o` depends combinationally on `ready_i`; there is no dependency on `valid_i`.

No arithmetic widening: the output width equals the input width, and the most negative value (-2^(WORD_SIZE-1)) is a legal input and output.

## Timing
Reset values:
- `count_r` = 0, `valid_o` = 0, `data_r_o` = 0, `max_r` = 0.
- `ready_o` = 1 in the first cycle after reset.

Reset mid-window: the partial window is discarded, and the next accepted word starts a new window.

Reset while `valid_o` = 1: the pending result is dropped, not drained.

Latency: `valid_o` rises on the same edge as the final accept, so the result is visible 1 cycle after the final word is presented.

Throughput: 1 input word per cycle sustained when `ready_i` = 1. One output per `POOL_SIZE` accepts.

Stall behaviour:
- While stalled (`valid_o=1`, `ready_i=0`), `data_r_o` and `valid_o` are stable.
- While stalled, up to `POOL_SIZE-1` words of the next window are absorbed. `ready_o` then drops until a drain.

When `valid_i=0`, no state other than the output drain changes.

The `count_r` wrap from `POOL_SIZE-1` to 0 occurs only on a final accept. Non-power-of-two `POOL_SIZE` must never reach an out-of-range count.

## Test plan
- **Basic window:** `POOL_SIZE`=4, `ready_i`=1, back-to-back inputs 3, -7, 12, 5. Required: `valid_o` pulses exactly 1 cycle, starting 1 cycle after the 4th accept, with `data_r_o`=12.
- **All-negative and extreme values:** inputs -32768, -1, -5, -32768. Required: `data_r_o` = -1. Then inputs -32768 ×4; required: `data_r_o` = -32768, which verifies the signed compare.
- **Backpressure:** `ready_i`=0, continuous `valid_i` with 1, 2, 3, 4, 9, 8, 7, 6.
  - Required: result 4 is held and `ready_o` stays 1 for words 9, 8, 7.
  - `ready_o`=0 while 6 is presented.
  - Raising `ready_i` drains 4 and accepts 6 in the same cycle, so `valid_o` stays 1 with `data_r_o`=9 next cycle.
- **Reset mid-window:** accept 100, 50, then pulse `reset_i` for 1 cycle, then accept 1, 2, 3, 4. Required: `valid_o`=0 right after reset, and exactly one result of 4 (not 100).
- **Randomised traffic:** random `valid_i` bubbles, random `ready_i`, random data, `POOL_SIZE` in {2, 3, 4, 5}. Required:
  - Output sequence matches a reference model of window maxima.
  - No word is lost or duplicated.
  - `data_r_o` and `valid_o` are stable while stalled.
